mapper_tx_wifi: RTL and testbench
=================================

Name: mapper_tx_wifi

Overview:
- WiFi PHY transmit-side constellation mapper: the counterpart of the RX demapper path.
- Accepts a serial coded/interleaved bit stream, one bit per cycle.
- Groups the bits into BPSK/QPSK/16-QAM symbols and emits 12-bit signed I/Q samples toward the IFFT/pilot-insertion stage.
- Single clock domain; the serial-to-parallel collection is internal.

Parameters:
- MAPPER, 2, modulation order: 2=BPSK (1 bit/symbol), 4=QPSK (2 bits), 16=16-QAM (4 bits). Any other value elaborates as BPSK.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- valid_in  input  1  data_in carries a valid bit this cycle
- data_in  input  1  serial bit; first bit received is b0
- last_in  input  1  qualifies the final bit of a frame; honoured only with valid_in
- valid_out  output  1  one-cycle pulse, I/Q sample valid
- data_out_real  output  12  signed I sample, two's complement
- data_out_imag  output  12  signed Q sample, two's complement
- busy  output  1  high while a partial symbol is held (bit count != 0)

Behaviour:
- Reset (reset=0, asynchronous):
  - valid_out=0, data_out_real=0, data_out_imag=0, busy=0.
  - Bit counter and shift register cleared.
  - Reset mid-symbol discards the partial bits; no output pulse.
- Collection:
  - K = log2(MAPPER). A bit counter runs 0..K-1.
  - On each valid_in, data_in is stored at position cnt, then cnt increments.
  - valid_in=0 holds state; gaps between bits are allowed.
- Symbol completion: when the accepted bit makes cnt==K-1, or last_in=1 accompanies valid_in:
  - Map the collected bits; any missing high positions are zero-padded.
  - Register the sample; valid_out=1 in the following cycle (latency 1 cycle from the completing bit).
  - cnt returns to 0.
  - A new bit arriving in the same cycle that valid_out is high is accepted normally, so back-to-back symbols are possible every K cycles.
- last_in behaviour:
  - last_in with valid_in=0 is ignored.
  - last_in on a bit that already completes a symbol produces exactly one symbol, not two.
- Outputs:
  - valid_out is high for exactly one cycle per symbol.
  - data_out_real/imag hold their last value until the next symbol.
- busy = (cnt != 0), combinational from the registered counter.
- Mapping (IEEE 802.11a Gray code). L1 = inner level, L3 = outer level, P = single-axis level:
  - BPSK: I = b0 ? +P : -P; Q = 0.
  - QPSK: I = b0 ? +P : -P; Q = b1 ? +P : -P.
  - 16-QAM, I from (b0,b1): 00 → -L3, 01 → -L1, 11 → +L1, 10 → +L3. Q from (b2,b3), same table.
- Levels without normalisation: P = 256, L1 = 256, L3 = 768.
- All levels are constants; no arithmetic overflow is possible within 12 bits.

Optional Feature:
- Macro: MAPPER_NORM_EN.
- Defined: outputs are scaled to unit average symbol energy, with 1.0 = 1024.
  - BPSK P = 1024.
  - QPSK P = 724.
  - 16-QAM L1 = 324, L3 = 971.
- Undefined: unnormalised levels P=256, L1=256, L3=768.
- Timing and handshake are identical in both builds.

Test Plan:
- MAPPER=2, no norm, bits 1,0,1 on consecutive cycles → three valid_out pulses, 1 cycle after each bit: I = +256, -256, +256; Q = 0; busy stays 0.
- MAPPER=4, no norm, bits 0,1 then 1,1 → pulse after the 2nd bit: I=-256, Q=+256; pulse after the 4th bit: I=+256, Q=+256; busy=1 between bits of a pair.
- MAPPER=16, no norm, bits 1,0,0,1 with a 3-cycle gap after bit 2 → one pulse only, 1 cycle after bit 4: I=+768, Q=-256; outputs hold until the next symbol.
- MAPPER=16, bits 0,1 then last_in with bit 1 (3 bits) → b3 padded 0, pulse with I=-256, Q=+768; cnt returns to 0, busy=0.
- MAPPER=4, one bit accepted then reset pulsed low for 1 cycle → all outputs 0 immediately; no valid_out; the next bit pair 1,0 gives I=+256, Q=-256.
- MAPPER=16 with MAPPER_NORM_EN, bits 1,1,1,0 → I=+324, Q=+971. MAPPER=4 with MAPPER_NORM_EN, bits 0,0 → I=-724, Q=-724.

Source files
------------

// File: rtl/mapper_tx_wifi.sv
// WiFi transmit constellation mapper: serial bits in, 12-bit signed I/Q out.
// Bits are collected LSB-first (b0 first) into a small shift register and
// mapped with the 802.11a Gray tables once a symbol is complete or last_in
// closes it early (missing high bits read as zero).
// Optional build macro: MAPPER_NORM_EN selects unit-average-energy levels
// (1.0 = 1024) instead of the raw 256/768 grid.
module mapper_tx_wifi #(
  parameter int MAPPER = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        data_in,
  input  logic        last_in,
  output logic        valid_out,
  output logic [11:0] data_out_real,
  output logic [11:0] data_out_imag,
  output logic        busy
);

  // Unsupported orders fall back to BPSK.
  localparam int K = (MAPPER == 16) ? 4 : (MAPPER == 4) ? 2 : 1;

`ifdef MAPPER_NORM_EN
  localparam logic signed [11:0] LVL_P  = (K == 2) ? 12'sd724 : 12'sd1024;
  localparam logic signed [11:0] LVL_L1 = 12'sd324;
  localparam logic signed [11:0] LVL_L3 = 12'sd971;
`else
  localparam logic signed [11:0] LVL_P  = 12'sd256;
  localparam logic signed [11:0] LVL_L1 = 12'sd256;
  localparam logic signed [11:0] LVL_L3 = 12'sd768;
`endif

  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  sh_q, sh_d;
  logic        vout_q, vout_d;
  logic [11:0] re_q, re_d;
  logic [11:0] im_q, im_d;
  logic [3:0]  bits;
  logic        done;

  // Gray-coded 4-PAM: first bit picks the sign, second bit picks inner level.
  function automatic logic [11:0] pam4(input logic sgn, input logic inner);
    logic signed [11:0] mag;
    mag = inner ? LVL_L1 : LVL_L3;
    return sgn ? mag : -mag;
  endfunction

  function automatic logic [11:0] bpsk(input logic b);
    return b ? LVL_P : -LVL_P;
  endfunction

  // Bit collection, symbol completion and sample mapping.
  always_comb begin
    bits = sh_q;
    if (valid_in) bits[cnt_q] = data_in;
    done   = valid_in && ((cnt_q == 2'(K - 1)) || last_in);
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    vout_d = done;
    re_d   = re_q;
    im_d   = im_q;
    if (done) begin
      cnt_d = 2'd0;
      sh_d  = 4'd0;
      case (K)
        4: begin
          re_d = pam4(bits[0], bits[1]);
          im_d = pam4(bits[2], bits[3]);
        end
        2: begin
          re_d = bpsk(bits[0]);
          im_d = bpsk(bits[1]);
        end
        default: begin
          re_d = bpsk(bits[0]);
          im_d = 12'd0;
        end
      endcase
    end else if (valid_in) begin
      cnt_d = 2'(cnt_q + 2'd1);
      sh_d  = bits;
    end
  end

  // State and output registers; reset discards any partial symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      sh_q   <= 4'd0;
      vout_q <= 1'b0;
      re_q   <= 12'd0;
      im_q   <= 12'd0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      vout_q <= vout_d;
      re_q   <= re_d;
      im_q   <= im_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    valid_out     = vout_q;
    data_out_real = re_q;
    data_out_imag = im_q;
    busy          = (cnt_q != 2'd0);
  end

endmodule

// File: tb/tb_mapper_tx_wifi.sv
module tb_mapper_tx_wifi;

`ifdef MAPPER_NORM_EN
  localparam int P2 = 1024;
  localparam int P4 = 724;
  localparam int L1 = 324;
  localparam int L3 = 971;
`else
  localparam int P2 = 256;
  localparam int P4 = 256;
  localparam int L1 = 256;
  localparam int L3 = 768;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vin [3];
  logic        din [3];
  logic        lin [3];
  logic        vout [3];
  logic [11:0] dre [3];
  logic [11:0] dim [3];
  logic        bsy [3];

  int vectors = 0;
  int errors  = 0;
  int exp_re [3];
  int exp_im [3];
  logic [23:0] sb [3][$];

  always #5 clk = ~clk;

  mapper_tx_wifi #(.MAPPER(2)) u_bpsk (
    .clk(clk), .reset(reset), .valid_in(vin[0]), .data_in(din[0]), .last_in(lin[0]),
    .valid_out(vout[0]), .data_out_real(dre[0]), .data_out_imag(dim[0]), .busy(bsy[0]));

  mapper_tx_wifi #(.MAPPER(4)) u_qpsk (
    .clk(clk), .reset(reset), .valid_in(vin[1]), .data_in(din[1]), .last_in(lin[1]),
    .valid_out(vout[1]), .data_out_real(dre[1]), .data_out_imag(dim[1]), .busy(bsy[1]));

  mapper_tx_wifi #(.MAPPER(16)) u_qam16 (
    .clk(clk), .reset(reset), .valid_in(vin[2]), .data_in(din[2]), .last_in(lin[2]),
    .valid_out(vout[2]), .data_out_real(dre[2]), .data_out_imag(dim[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic expect_sym(input int d, input int re, input int im);
    sb[d].push_back({12'(re), 12'(im)});
  endtask

  // Check output registers of DUT d against the last expected symbol.
  task automatic chk_data(input int d, input string tag);
    chk({tag, "_re"}, int'($signed(dre[d])), exp_re[d]);
    chk({tag, "_im"}, int'($signed(dim[d])), exp_im[d]);
  endtask

  // One clock: drive, then sample #1 after the rising edge.
  task automatic step(input int d, input bit v, input bit b, input bit l,
                      input bit exp_done, input bit exp_busy, input string tag);
    logic [23:0] e;
    vin[d] = v; din[d] = b; lin[d] = l;
    @(posedge clk);
    #1;
    vin[d] = 1'b0; din[d] = 1'b0; lin[d] = 1'b0;
    chk({tag, "_valid"}, int'(vout[d]), int'(exp_done));
    chk({tag, "_busy"}, int'(bsy[d]), int'(exp_busy));
    if (exp_done) begin
      if (sb[d].size() == 0) begin
        chk({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = sb[d].pop_front();
        exp_re[d] = int'($signed(e[23:12]));
        exp_im[d] = int'($signed(e[11:0]));
      end
    end
    chk_data(d, tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; din[i] = 1'b0; lin[i] = 1'b0;
      exp_re[i] = 0; exp_im[i] = 0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", int'(vout[i]), 0);
      chk("rst_busy", int'(bsy[i]), 0);
      chk_data(i, "rst");
    end
    reset = 1'b1;
    @(posedge clk); #1;

    // BPSK: every bit is a symbol
    expect_sym(0, P2, 0);  step(0, 1, 1, 0, 1, 0, "bpsk0");
    expect_sym(0, -P2, 0); step(0, 1, 0, 0, 1, 0, "bpsk1");
    expect_sym(0, P2, 0);  step(0, 1, 1, 0, 1, 0, "bpsk2");
    step(0, 0, 0, 0, 0, 0, "bpsk_idle");

    // QPSK pairs
    step(1, 1, 0, 0, 0, 1, "qpsk_a0");
    expect_sym(1, -P4, P4); step(1, 1, 1, 0, 1, 0, "qpsk_a1");
    step(1, 1, 1, 0, 0, 1, "qpsk_b0");
    expect_sym(1, P4, P4);  step(1, 1, 1, 0, 1, 0, "qpsk_b1");
    step(1, 1, 0, 0, 0, 1, "qpsk_c0");
    expect_sym(1, -P4, -P4); step(1, 1, 0, 0, 1, 0, "qpsk_c1");
    // last_in without valid_in is ignored
    step(1, 1, 1, 0, 0, 1, "qpsk_d0");
    step(1, 0, 0, 1, 0, 1, "qpsk_lastnov");
    expect_sym(1, P4, P4); step(1, 1, 1, 0, 1, 0, "qpsk_d1");

    // 16-QAM with a gap mid-symbol, then hold
    step(2, 1, 1, 0, 0, 1, "qam_a0");
    step(2, 1, 0, 0, 0, 1, "qam_a1");
    for (int i = 0; i < 3; i++) step(2, 0, 0, 0, 0, 1, "qam_gap");
    step(2, 1, 0, 0, 0, 1, "qam_a2");
    expect_sym(2, L3, -L1); step(2, 1, 1, 0, 1, 0, "qam_a3");
    step(2, 0, 0, 0, 0, 0, "qam_hold0");
    step(2, 0, 0, 0, 0, 0, "qam_hold1");
    // early termination: b3 padded with zero
    step(2, 1, 0, 0, 0, 1, "qam_b0");
    step(2, 1, 1, 0, 0, 1, "qam_b1");
    expect_sym(2, -L1, L3); step(2, 1, 1, 1, 1, 0, "qam_b2last");
    // back-to-back symbol
    step(2, 1, 1, 0, 0, 1, "qam_c0");
    step(2, 1, 1, 0, 0, 1, "qam_c1");
    step(2, 1, 1, 0, 0, 1, "qam_c2");
    expect_sym(2, L1, L3); step(2, 1, 0, 0, 1, 0, "qam_c3");
    // last_in on a completing bit yields exactly one symbol
    step(2, 1, 1, 0, 0, 1, "qam_d0");
    step(2, 1, 0, 0, 0, 1, "qam_d1");
    step(2, 1, 1, 0, 0, 1, "qam_d2");
    expect_sym(2, L3, L1); step(2, 1, 1, 1, 1, 0, "qam_d3last");
    step(2, 0, 0, 0, 0, 0, "qam_d_nodup");

    // reset mid-symbol on QPSK
    step(1, 1, 1, 0, 0, 1, "qpsk_pre_rst");
    reset = 1'b0;
    #2;
    exp_re[1] = 0; exp_im[1] = 0;
    chk("rst_mid_valid", int'(vout[1]), 0);
    chk("rst_mid_busy", int'(bsy[1]), 0);
    chk_data(1, "rst_mid");
    @(posedge clk); #1;
    reset = 1'b1;
    step(1, 0, 0, 0, 0, 0, "qpsk_post_rst");
    step(1, 1, 1, 0, 0, 1, "qpsk_e0");
    expect_sym(1, P4, -P4); step(1, 1, 0, 0, 1, 0, "qpsk_e1");

    for (int i = 0; i < 3; i++) chk("sb_leftover", sb[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
